// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared types and limits for the dot-product sequencer.
// Holds the FSM state encoding, default widths and the memory latency cap.
package dotprod_pkg;

  localparam int N_W_DEF     = 32;
  localparam int MEM_LAT_MAX = 4;
  localparam int DRAIN_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Keep the operand-memory latency inside the supported 1..MAX window.
  function automatic int clamp_lat(input int lat);
    if (lat < 1)
      return 1;
    else if (lat > MEM_LAT_MAX)
      return MEM_LAT_MAX;
    else
      return lat;
  endfunction

endpackage

// File: rtl/dotprod_valid_pipe.sv
// dotprod_valid_pipe: resettable, flushable strobe delay line.
// Delays the read strobe by the memory latency to form the MAC enable.
module dotprod_valid_pipe
  import dotprod_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_vld,
  output logic out_vld
);

  localparam int DEPTH = clamp_lat(LAT);

  logic [DEPTH-1:0] sr;

  // Shift the strobe one stage per cycle; reset or flush empties it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr <= '0;
    end else begin
      sr[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign out_vld = sr[DEPTH-1];

endmodule

// File: rtl/dotprod_ctrl.sv
// dotprod_ctrl: sequencer driving operand reads and a shared MAC.
// Optional abort path enabled by defining DOTPROD_CTRL_ABORT_EN.
module dotprod_ctrl
  import dotprod_pkg::*;
#(
  parameter int N_W     = N_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
`ifdef DOTPROD_CTRL_ABORT_EN
  input  logic           abort,
  output logic           aborted,
`endif
  output logic           busy,
  output logic           rd_en,
  output logic [N_W-1:0] addr,
  output logic           mac_clr,
  output logic           mac_en,
  input  logic [N_W-1:0] acc_in,
  output logic           done,
  output logic [N_W-1:0] return_val
);

  localparam int LAT = clamp_lat(MEM_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT);

  state_t             state_q;
  state_t             state_d;
  logic [N_W-1:0]     n_q;
  logic [N_W-1:0]     idx_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [N_W-1:0]     rv_q;
  logic               kill;
  logic               zero_n;
  logic               last_issue;
  logic               drain_end;
  logic               enter_done;

`ifdef DOTPROD_CTRL_ABORT_EN
  logic aborted_q;

  assign kill = abort && (state_q != S_IDLE);

  // One-cycle aborted pulse in the cycle after the abort is taken.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      aborted_q <= 1'b0;
    else
      aborted_q <= kill;
  end

  assign aborted = aborted_q;
`else
  assign kill = 1'b0;
`endif

  assign zero_n     = (n_q == '0);
  assign last_issue = (idx_q == n_q - N_W'(1));
  assign drain_end  = (drain_q == DRAIN_LAST);
  assign enter_done = (state_d == S_DONE) &&
                      (state_q != S_DONE);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state decode; abort overrides every busy state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = zero_n ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill)
      state_d = S_IDLE;
  end

  // Job length latch and element index.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      n_q   <= '0;
      idx_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        n_q   <= n;
        idx_q <= '0;
      end
    end else if (state_q == S_ISSUE) begin
      idx_q <= idx_q + N_W'(1);
    end
  end

  // Drain timer covers the memory latency plus one MAC cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      drain_q <= '0;
    else if (state_q == S_DRAIN)
      drain_q <= drain_q + DRAIN_W'(1);
    else
      drain_q <= '0;
  end

  // Result capture; an empty job reports zero since the clear
  // lands on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      rv_q <= '0;
    else if (enter_done)
      rv_q <= (state_q == S_CLEAR) ? '0 : acc_in;
  end

  dotprod_valid_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .flush   (kill),
    .in_vld  (rd_en),
    .out_vld (mac_en)
  );

  // Moore outputs decoded from the current state.
  always_comb begin
    busy    = 1'b0;
    rd_en   = 1'b0;
    mac_clr = 1'b0;
    done    = 1'b0;
    addr    = '0;
    unique case (1'b1)
      (state_q == S_CLEAR): begin
        busy    = 1'b1;
        mac_clr = 1'b1;
      end
      (state_q == S_ISSUE): begin
        busy  = 1'b1;
        rd_en = 1'b1;
        addr  = idx_q;
      end
      (state_q == S_DRAIN): busy = 1'b1;
      (state_q == S_DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign return_val = rv_q;

endmodule

// File: tb/tb_dotprod_ctrl.sv
// tb_dotprod_ctrl: scoreboard bench for dotprod_ctrl.
// Two instances: MEM_LAT=1 (index 0) and MEM_LAT=3 (index 1).
module tb_dotprod_ctrl;

  localparam int W    = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    int         dcyc;
    int         ccyc;
    int         macs;
    logic [W-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]   rst;
  logic [1:0]   start;
  logic [1:0]   busy;
  logic [1:0]   rd_en;
  logic [1:0]   mac_clr;
  logic [1:0]   mac_en;
  logic [1:0]   done;
  logic [W-1:0] n_in [2];
  logic [W-1:0] addr [2];
  logic [W-1:0] acc  [2];
  logic [W-1:0] rv   [2];
  int           pat  [2];
`ifdef DOTPROD_CTRL_ABORT_EN
  logic [1:0]   abort;
  logic [1:0]   aborted;
`endif

  dotprod_ctrl #(.N_W(W), .MEM_LAT(LAT0)) u_dut0 (
    .sys_clk    (clk),
    .sys_rst    (rst[0]),
    .start      (start[0]),
    .n          (n_in[0]),
`ifdef DOTPROD_CTRL_ABORT_EN
    .abort      (abort[0]),
    .aborted    (aborted[0]),
`endif
    .busy       (busy[0]),
    .rd_en      (rd_en[0]),
    .addr       (addr[0]),
    .mac_clr    (mac_clr[0]),
    .mac_en     (mac_en[0]),
    .acc_in     (acc[0]),
    .done       (done[0]),
    .return_val (rv[0])
  );

  dotprod_ctrl #(.N_W(W), .MEM_LAT(LAT1)) u_dut1 (
    .sys_clk    (clk),
    .sys_rst    (rst[1]),
    .start      (start[1]),
    .n          (n_in[1]),
`ifdef DOTPROD_CTRL_ABORT_EN
    .abort      (abort[1]),
    .aborted    (aborted[1]),
`endif
    .busy       (busy[1]),
    .rd_en      (rd_en[1]),
    .addr       (addr[1]),
    .mac_clr    (mac_clr[1]),
    .mac_en     (mac_en[1]),
    .acc_in     (acc[1]),
    .done       (done[1]),
    .return_val (rv[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // pattern 0: a[i]=i, b[i]=1 ; pattern 1: a=b=2
  function automatic logic [W-1:0] prod(input int p, input logic [W-1:0] a);
    return (p == 0) ? a : W'(4);
  endfunction

  // Operand memory + MAC model: address history stands in for read latency.
  logic [W-1:0] ah [2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i] || mac_clr[i])
        acc[i] <= '0;
      else if (mac_en[i])
        acc[i] <= acc[i] + prod(pat[i], ah[i][lat(i)-1]);
      ah[i][0] <= addr[i];
      for (int k = 1; k < 4; k++)
        ah[i][k] <= ah[i][k-1];
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  exp_t         dq  [2][$];
  logic [W-1:0] aq  [2][$];
  int           abq [2][$];
  int           mac_cnt  [2];
  int           last_clr [2];
  logic [3:0]   rh [2];

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        mac_cnt[i] = 0;
        rh[i] = '0;
      end else begin
        if (mac_clr[i])
          last_clr[i] = cyc;
        if (rd_en[i]) begin
          if (aq[i].size() == 0)
            chk($sformatf("d%0d_unexpected_rd", i), 1, 0);
          else
            chk($sformatf("d%0d_addr", i), addr[i], aq[i].pop_front());
        end
        if (mac_en[i] || rh[i][lat(i)-1])
          chk($sformatf("d%0d_mac_lag", i), mac_en[i], rh[i][lat(i)-1]);
        if (mac_en[i])
          mac_cnt[i]++;
        rh[i] = {rh[i][2:0], rd_en[i]};
        if (done[i]) begin
          if (dq[i].size() == 0) begin
            chk($sformatf("d%0d_unexpected_done", i), 1, 0);
          end else begin
            exp_t e;
            e = dq[i].pop_front();
            chk($sformatf("d%0d_done_cyc", i), cyc, e.dcyc);
            chk($sformatf("d%0d_clr_cyc", i), last_clr[i], e.ccyc);
            chk($sformatf("d%0d_mac_cnt", i), mac_cnt[i], e.macs);
            chk($sformatf("d%0d_ret", i), rv[i], e.val);
          end
          mac_cnt[i] = 0;
        end
`ifdef DOTPROD_CTRL_ABORT_EN
        if (aborted[i]) begin
          if (abq[i].size() == 0)
            chk($sformatf("d%0d_unexpected_abort", i), 1, 0);
          else
            chk($sformatf("d%0d_abort_cyc", i), cyc, abq[i].pop_front());
          mac_cnt[i] = 0;
        end
        if (abort[i])
          rh[i] = '0;
`endif
      end
    end
  end

  // Issue a job: push addresses and the done record, pulse start.
  task automatic job(input int i, input int nn, input int p,
                     input logic [W-1:0] val);
    exp_t e;
    int   b;
    pat[i]   = p;
    n_in[i]  = W'(nn);
    start[i] = 1'b1;
    b = cyc;
    for (int a = 0; a < nn; a++)
      aq[i].push_back(W'(a));
    e.dcyc = (nn == 0) ? b + 2 : b + nn + lat(i) + 3;
    e.ccyc = b + 1;
    e.macs = nn;
    e.val  = val;
    dq[i].push_back(e);
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // Wait for outstanding done records with a cycle budget.
  task automatic drain(input int i, input int budget);
    int k;
    k = 0;
    while (dq[i].size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk($sformatf("d%0d_done_timeout", i), dq[i].size(), 0);
    chk($sformatf("d%0d_addr_left", i), aq[i].size(), 0);
    dq[i].delete();
    aq[i].delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst   = 2'b11;
    start = 2'b00;
    n_in[0] = '0;
    n_in[1] = '0;
    pat[0] = 0;
    pat[1] = 0;
`ifdef DOTPROD_CTRL_ABORT_EN
    abort = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_busy", i), busy[i], 0);
      chk($sformatf("d%0d_rst_addr", i), addr[i], 0);
      chk($sformatf("d%0d_rst_ret", i), rv[i], 0);
      chk($sformatf("d%0d_rst_macen", i), mac_en[i], 0);
    end
    @(posedge clk); #1;

    // n=10, a=i, b=1 -> 45, done cycle 14
    job(0, 10, 0, 8'd45);
    drain(0, 100);
    chk("d0_ret_hold45", rv[0], 45);

    // n=0 -> done cycle 2, result 0
    job(0, 0, 0, 8'd0);
    drain(0, 50);
    chk("d0_ret_zero", rv[0], 0);

    // MEM_LAT=3, n=4, a=b=2 -> 16, done cycle 10
    job(1, 4, 1, 8'd16);
    drain(1, 100);
    job(1, 0, 1, 8'd0);
    drain(1, 50);

    // Start pulsed while busy is ignored; start held restarts after DONE.
    b = cyc;
    pat[0] = 0;
    n_in[0] = W'(5);
    start[0] = 1'b1;
    for (int a = 0; a < 5; a++) aq[0].push_back(W'(a));
    for (int a = 0; a < 2; a++) aq[0].push_back(W'(a));
    dq[0].push_back('{b + 9, b + 1, 5, 8'd10});
    dq[0].push_back('{b + 16, b + 11, 2, 8'd1});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      case (k)
        1: start[0] = 1'b0;
        3: begin start[0] = 1'b1; n_in[0] = W'(2); end
        4: start[0] = 1'b0;
        7: start[0] = 1'b1;
        12: start[0] = 1'b0;
        default: ;
      endcase
    end
    drain(0, 100);

    // Largest count: 0+1+..+254 mod 256 = 129, no index wrap
    job(0, 255, 0, 8'd129);
    drain(0, 400);

    // Reset in cycle 6 of an n=10 job abandons it
    b = cyc;
    pat[0] = 0;
    n_in[0] = W'(10);
    start[0] = 1'b1;
    for (int a = 0; a < 10; a++) aq[0].push_back(W'(a));
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) start[0] = 1'b0;
      if (k == 6) rst[0] = 1'b1;
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    aq[0].delete();
    @(negedge clk);
    chk("d0_mid_rst_busy", busy[0], 0);
    chk("d0_mid_rst_rd", rd_en[0], 0);
    chk("d0_mid_rst_addr", addr[0], 0);
    chk("d0_mid_rst_clr", mac_clr[0], 0);
    chk("d0_mid_rst_macen", mac_en[0], 0);
    chk("d0_mid_rst_done", done[0], 0);
    chk("d0_mid_rst_ret", rv[0], 0);
    repeat (20) @(posedge clk);
    #1;
    job(0, 3, 0, 8'd3);
    drain(0, 100);

`ifdef DOTPROD_CTRL_ABORT_EN
    // Abort in cycle 5 of an n=10 job
    b = cyc;
    pat[0] = 0;
    n_in[0] = W'(10);
    start[0] = 1'b1;
    for (int a = 0; a < 4; a++) aq[0].push_back(W'(a));
    abq[0].push_back(b + 6);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) start[0] = 1'b0;
      if (k == 5) abort[0] = 1'b1;
      if (k == 6) abort[0] = 1'b0;
    end
    @(negedge clk);
    chk("d0_abort_busy", busy[0], 0);
    chk("d0_abort_ret", rv[0], 3);
    repeat (20) @(posedge clk);
    #1;
    chk("d0_abort_left", abq[0].size(), 0);
    chk("d0_abort_addr_left", aq[0].size(), 0);
    chk("d0_abort_ret_hold", rv[0], 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dotprod_ctrl.md
DOTPROD_CTRL -- requirements
Module: dotprod_ctrl

Interface
REQ-001 SHALL have parameter: N_W, 32, width of element count, address and result.
REQ-002 SHALL have parameter: MEM_LAT, 1, operand-memory read latency in cycles (legal 1..4).
REQ-003 SHALL have port: sys_clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: sys_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  in  1  job request, sampled only in IDLE.
REQ-006 SHALL have port: n  in  N_W  element count, latched when start is accepted.
REQ-007 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port: rd_en, addr  out  1, N_W  operand read strobe and element index.
REQ-009 SHALL have port: mac_clr, mac_en  out  1, 1  accumulator clear and accumulate strobes.
REQ-010 SHALL have port: acc_in  in  N_W  accumulator value from the shared MAC.
REQ-011 SHALL have port: done, return_val  out  1, N_W  one-cycle completion pulse and held result.

Function
REQ-012 SHALL implement FSM IDLE -> CLEAR -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-013 IDLE: start=1 SHALL latch n, clear index to 0 and go to CLEAR next edge; start while busy SHALL be ignored.
REQ-014 CLEAR: mac_clr=1 for exactly one cycle; latched n==0 SHALL go directly to DONE, else to ISSUE.
REQ-015 ISSUE: rd_en=1, addr=index each cycle; index increments by 1; state SHALL stay in ISSUE for exactly n cycles (addr 0..n-1), then go to DRAIN.
REQ-016 mac_en SHALL equal rd_en delayed by exactly MEM_LAT cycles; exactly n mac_en pulses per job.
REQ-017 DRAIN: SHALL last MEM_LAT+1 cycles (last read plus one MAC cycle), rd_en=0.
REQ-018 DONE: done=1 for one cycle; return_val SHALL load acc_in on the edge entering DONE and hold until the next DONE.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high in cycle n+MEM_LAT+3 (cycle 2 for n==0).
REQ-020 index arithmetic SHALL be unsigned N_W-bit; n=2^N_W-1 SHALL issue without wrap (compare to latched n-1, not n).
REQ-021 start held high through DONE SHALL start a new job on the edge after DONE (IDLE sees start); no back-to-back restart from DONE.
REQ-022 n changing while busy SHALL have no effect on the current job.

Reset
REQ-023 sys_rst=1 SHALL, on the next edge, force IDLE, clear index, mac_en pipeline, busy, rd_en, mac_clr, mac_en, done to 0, addr and return_val to 0.
REQ-024 Reset mid-job SHALL abandon the job with no done pulse and no further mac_en.

Configuration
REQ-025 With DOTPROD_CTRL_ABORT_EN defined: extra input abort (1 bit); abort=1 in any non-IDLE state SHALL return to IDLE next edge, drop rd_en and flush the mac_en pipeline, leave return_val unchanged, and pulse output aborted (1 bit) for one cycle instead of done.
REQ-026 Without DOTPROD_CTRL_ABORT_EN: no abort/aborted ports; jobs always run to DONE.

Structure
REQ-027 Package dotprod_pkg SHALL hold the FSM state enum, N_W default and MEM_LAT maximum (4).
REQ-028 Sub-module dotprod_valid_pipe SHALL implement the MEM_LAT-deep resettable strobe delay line producing mac_en.

Verification
REQ-029 n=10, MEM_LAT=1, a[i]=i, b[i]=1 via model MAC -> addr 0..9, 10 mac_en pulses, done in cycle 14, return_val=45.
REQ-030 n=0 -> mac_clr cycle 1, no rd_en/mac_en, done cycle 2, return_val=0.
REQ-031 MEM_LAT=3, n=4, a=b=2 -> mac_en lags rd_en by 3, done cycle 10, return_val=16.
REQ-032 start pulsed during ISSUE of n=5 job -> ignored; exactly one done; start held high -> second job begins cycle after done.
REQ-033 sys_rst asserted at cycle 6 of n=10 job -> all outputs 0 next edge, no done; fresh n=3 job then completes normally.
REQ-034 ABORT_EN build: abort at cycle 5 of n=10 -> IDLE next edge, aborted pulse, no done, return_val unchanged.
